// File: rtl/run_ctrl.sv
// run_ctrl: PC register and run/step/stop sequencer for the single-cycle Y86 core.
// Define RUN_CTRL_BP_EN to build the NUM_BP PC breakpoint comparators and the resume-skip flag.
module run_ctrl #(
   parameter int unsigned     PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     NUM_BP   = 4,
   parameter int unsigned     CYC_W    = 32,
   localparam int unsigned    BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                step_i,
   input  logic                stop_i,
   input  logic [PC_W-1:0]     nw_pc_i,
   input  logic [2:0]          stat_i,
   input  logic                bp_wr_i,
   input  logic [BP_IDX_W-1:0] bp_idx_i,
   input  logic                bp_en_i,
   input  logic [PC_W-1:0]     bp_addr_i,
   input  logic [CYC_W-1:0]    cyc_limit_i,
   output logic [PC_W-1:0]     pc_o,
   output logic                commit_o,
   output logic [1:0]          state_o,
   output logic [2:0]          halt_cause_o,
   output logic [CYC_W-1:0]    cycle_cnt_o,
   output logic [CYC_W-1:0]    instr_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_HALT = 2'b11
   } state_e;

   state_e           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [2:0]       cause_q;
   logic [CYC_W-1:0] cyc_q;
   logic [CYC_W-1:0] ins_q;

   logic             active_d;
   logic             bp_hit_d;
   logic             hit_d;
   logic [2:0]       hit_cause_d;
   logic [CYC_W-1:0] cyc_inc_d;
   logic [CYC_W-1:0] ins_inc_d;

`ifdef RUN_CTRL_BP_EN
   logic [NUM_BP-1:0] bp_en_q;
   logic [PC_W-1:0]   bp_addr_q [NUM_BP];
   logic              skip_q;

   always_comb begin
      bp_hit_d = 1'b0;
      for (int unsigned i = 0; i < NUM_BP; i++) begin
         if (bp_en_q[i] && (bp_addr_q[i] == pc_q)) begin
            bp_hit_d = 1'b1;
         end
      end
      bp_hit_d = bp_hit_d && !skip_q;
   end

   // Skip lets a resumed run step off the breakpoint it halted on.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bp_en_q <= '0;
         skip_q  <= 1'b0;
         for (int unsigned i = 0; i < NUM_BP; i++) begin
            bp_addr_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (bp_wr_i && (32'(bp_idx_i) == i)) begin
               bp_en_q[i]   <= bp_en_i;
               bp_addr_q[i] <= bp_addr_i;
            end
         end
         if ((state_q == S_HALT) && (start_i || step_i)) begin
            skip_q <= 1'b1;
         end else if (commit_o) begin
            skip_q <= 1'b0;
         end
      end
   end
`else
   logic unused_bp;
   assign unused_bp = ^{bp_wr_i, bp_idx_i, bp_en_i, bp_addr_i};
   assign bp_hit_d  = 1'b0;
`endif

   always_comb begin
      active_d = (state_q == S_RUN) || (state_q == S_STEP);
      case (stat_i)
         3'd1:    hit_cause_d = 3'd0;
         3'd2:    hit_cause_d = 3'd1;
         3'd3:    hit_cause_d = 3'd2;
         3'd4:    hit_cause_d = 3'd3;
         default: hit_cause_d = 3'd7;
      endcase
      if (hit_cause_d == 3'd0) begin
         if (bp_hit_d) begin
            hit_cause_d = 3'd4;
         end else if ((cyc_limit_i != '0) && (cyc_q == cyc_limit_i)) begin
            hit_cause_d = 3'd5;
         end else if (stop_i) begin
            hit_cause_d = 3'd6;
         end
      end
      hit_d     = active_d && (hit_cause_d != 3'd0);
      cyc_inc_d = (&cyc_q) ? cyc_q : cyc_q + CYC_W'(1);
      ins_inc_d = (&ins_q) ? ins_q : ins_q + CYC_W'(1);
   end

   assign commit_o = active_d && !hit_d && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         cause_q <= '0;
         cyc_q   <= '0;
         ins_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i || step_i) begin
                  state_q <= start_i ? S_RUN : S_STEP;
                  cyc_q   <= '0;
                  ins_q   <= '0;
               end
            end
            S_HALT: begin
               if (start_i || step_i) begin
                  state_q <= start_i ? S_RUN : S_STEP;
                  cause_q <= '0;
               end
            end
            default: begin
               cyc_q <= cyc_inc_d;
               if (hit_d) begin
                  state_q <= S_HALT;
                  cause_q <= hit_cause_d;
               end else begin
                  pc_q  <= nw_pc_i;
                  ins_q <= ins_inc_d;
                  if (state_q == S_STEP) begin
                     state_q <= S_HALT;
                     cause_q <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign pc_o         = pc_q;
   assign state_o      = state_q;
   assign halt_cause_o = cause_q;
   assign cycle_cnt_o  = cyc_q;
   assign instr_cnt_o  = ins_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_run_ctrl;

   localparam int unsigned PC_W   = 16;
   localparam int unsigned NUM_BP = 3;
   localparam int unsigned CYC_W  = 8;
   localparam int          CMAX   = (1 << CYC_W) - 1;
`ifdef RUN_CTRL_BP_EN
   localparam bit BP_ON = 1'b1;
`else
   localparam bit BP_ON = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i, start_i, step_i, stop_i;
   logic [PC_W-1:0]  nw_pc_i;
   logic [2:0]       stat_i;
   logic             bp_wr_i, bp_en_i;
   logic [1:0]       bp_idx_i;
   logic [PC_W-1:0]  bp_addr_i;
   logic [CYC_W-1:0] cyc_limit_i;
   logic [PC_W-1:0]  pc_o;
   logic             commit_o;
   logic [1:0]       state_o;
   logic [2:0]       halt_cause_o;
   logic [CYC_W-1:0] cycle_cnt_o, instr_cnt_o;

   run_ctrl #(.PC_W(PC_W), .RESET_PC(16'h0), .NUM_BP(NUM_BP), .CYC_W(CYC_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .step_i(step_i), .stop_i(stop_i),
      .nw_pc_i(nw_pc_i), .stat_i(stat_i), .bp_wr_i(bp_wr_i), .bp_idx_i(bp_idx_i),
      .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .cyc_limit_i(cyc_limit_i),
      .pc_o(pc_o), .commit_o(commit_o), .state_o(state_o), .halt_cause_o(halt_cause_o),
      .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model state: 0 idle, 1 run, 2 step, 3 halt (same numbering as state_o).
   int              m_st    = 0;
   logic [PC_W-1:0] m_pc    = '0;
   int              m_cause = 0;
   int              m_cyc   = 0;
   int              m_ins   = 0;
   bit              m_skip  = 1'b0;
   bit              m_valid = 1'b0;
   bit              m_en   [NUM_BP];
   logic [PC_W-1:0] m_addr [NUM_BP];
   logic [PC_W-1:0] delta  = '0;

   function automatic int exp_cause();
      if (m_st != 1 && m_st != 2) return 0;
      if (stat_i == 3'd2) return 1;
      if (stat_i == 3'd3) return 2;
      if (stat_i == 3'd4) return 3;
      if (stat_i != 3'd1) return 7;
      if (BP_ON && !m_skip) begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (m_en[i] && m_addr[i] == m_pc) return 4;
         end
      end
      if (cyc_limit_i != 0 && m_cyc == int'(cyc_limit_i)) return 5;
      if (stop_i) return 6;
      return 0;
   endfunction

   task automatic tick();
      int hc;
      bit ec;
      nw_pc_i = m_pc + delta;
      @(negedge clk_i);
      hc = exp_cause();
      ec = !rst_i && (m_st == 1 || m_st == 2) && hc == 0;
      if (m_valid) begin
         check("commit", commit_o, ec);
         check("state", state_o, m_st);
         check("pc", pc_o, m_pc);
         check("cause", halt_cause_o, m_cause);
         check("cycle_cnt", cycle_cnt_o, m_cyc);
         check("instr_cnt", instr_cnt_o, m_ins);
      end
      if (rst_i) begin
         m_valid = 1'b1;
         m_st = 0; m_pc = '0; m_cause = 0; m_cyc = 0; m_ins = 0; m_skip = 1'b0;
         for (int i = 0; i < NUM_BP; i++) begin
            m_en[i] = 1'b0;
            m_addr[i] = '0;
         end
      end else begin
         if (m_st == 0 || m_st == 3) begin
            if (start_i || step_i) begin
               if (m_st == 0) begin
                  m_cyc = 0;
                  m_ins = 0;
               end else begin
                  m_skip = 1'b1;
               end
               m_st = start_i ? 1 : 2;
               m_cause = 0;
            end
         end else begin
            if (m_cyc < CMAX) m_cyc++;
            if (hc != 0) begin
               m_cause = hc;
               m_st = 3;
            end else begin
               m_pc = nw_pc_i;
               if (m_ins < CMAX) m_ins++;
               m_skip = 1'b0;
               if (m_st == 2) begin
                  m_st = 3;
                  m_cause = 0;
               end
            end
         end
         if (bp_wr_i && bp_idx_i < NUM_BP) begin
            m_en[bp_idx_i] = bp_en_i;
            m_addr[bp_idx_i] = bp_addr_i;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      rst_i = 1'b0; start_i = 1'b0; step_i = 1'b0; stop_i = 1'b0; stat_i = 3'd1;
      bp_wr_i = 1'b0; bp_idx_i = '0; bp_en_i = 1'b0; bp_addr_i = '0; cyc_limit_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      check("rst_pc", pc_o, 0);
      check("rst_state", state_o, 0);
      check("rst_cnt", cycle_cnt_o, 0);

      // run with +10 per instruction
      pulse_start();
      delta = 16'd10;
      repeat (5) tick();
      check("t1_pc", pc_o, 50);
      check("t1_cnt_eq", instr_cnt_o, 5);

      // HLT status at 0x30
      do_reset();
      pulse_start();
      delta = 16'h10;
      repeat (3) tick();
      stat_i = 3'd2;
      tick();
      stat_i = 3'd1;
      check("t2_state", state_o, 3);
      check("t2_cause", halt_cause_o, 1);
      check("t2_pc", pc_o, 16'h30);

      // breakpoint at 0x14, then resume past it
      do_reset();
      bp_wr_i = 1'b1; bp_idx_i = 2'd0; bp_en_i = 1'b1; bp_addr_i = 16'h14;
      tick();
      bp_wr_i = 1'b0;
      pulse_start();
      delta = 16'd10;
      repeat (4) tick();
      pulse_start();
      tick();
      tick();

      // single step x3 with +2
      do_reset();
      delta = 16'd2;
      repeat (3) begin
         step_i = 1'b1;
         tick();
         step_i = 1'b0;
         tick();
      end
      check("t4_pc", pc_o, 6);
      check("t4_instr", instr_cnt_o, 3);
      check("t4_state", state_o, 3);

      // cycle limit 5
      do_reset();
      cyc_limit_i = 8'd5;
      pulse_start();
      delta = 16'd1;
      repeat (8) tick();
      check("t5_cause", halt_cause_o, 5);
      check("t5_instr", instr_cnt_o, 5);
      cyc_limit_i = '0;

      // reset mid-run, then ADR status
      do_reset();
      pulse_start();
      delta = 16'h10;
      repeat (4) tick();
      check("t6_pc40", pc_o, 16'h40);
      do_reset();
      check("t6_pc", pc_o, 0);
      check("t6_state", state_o, 0);
      check("t6_instr", instr_cnt_o, 0);
      pulse_start();
      stat_i = 3'd3;
      tick();
      stat_i = 3'd1;
      check("t6_cause", halt_cause_o, 2);

      // out-of-range slot write, start+stop together, counter saturation
      do_reset();
      bp_wr_i = 1'b1; bp_idx_i = 2'd3; bp_en_i = 1'b1; bp_addr_i = 16'h0;
      tick();
      bp_wr_i = 1'b0;
      start_i = 1'b1; stop_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      stop_i = 1'b0;
      pulse_start();
      delta = 16'd1;
      repeat (300) tick();
      check("sat_cyc", cycle_cnt_o, CMAX);
      check("sat_instr", instr_cnt_o, CMAX);

      // random traffic
      do_reset();
      repeat (3000) begin
         rst_i   = ($urandom_range(0, 199) == 0);
         start_i = ($urandom_range(0, 7) == 0);
         step_i  = ($urandom_range(0, 7) == 0);
         stop_i  = ($urandom_range(0, 15) == 0);
         stat_i  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
         bp_wr_i = ($urandom_range(0, 7) == 0);
         bp_idx_i  = 2'($urandom_range(0, 3));
         bp_en_i   = 1'($urandom_range(0, 1));
         bp_addr_i = 16'($urandom_range(0, 15) * 2);
         cyc_limit_i = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 40)) : 8'd0;
         delta = 16'($urandom_range(0, 15) * 2) - m_pc;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
